pipe_skid_reg: RTL and testbench

Parametrised, elastic successor to the fixed IF/ID pipeline register. It carries a WIDTH-bit payload between two pipeline stages using a valid/ready handshake, and keeps the existing flush and freeze controls. A 2-entry skid buffer sustains one transfer per cycle with no combinational path from out_ready to in_ready. It is placed between any two stages of the ARM pipeline, replacing the hard-wired 64-bit stage registers.

---
 rtl/pipe_skid_reg.sv | 79 +++++++
 tb/tb_pipe_skid_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic two-entry skid pipeline register with flush and freeze
module pipe_skid_reg #(
    parameter int WIDTH      = 64,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    // in_ready is a function of registered state only, so out_ready never reaches it
    assign in_ready  = (state != TWO) & ~freeze & rst;
    assign out_valid = (state != EMPTY) & ~freeze;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = main_q;
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (CLEAR_DATA) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else if (!freeze) begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        state  <= TWO;
                        skid_q <= in_data;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, flush, freeze, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid, in_ready_nc, out_valid_nc;
    logic [W-1:0] out_data, out_data_nc;
    logic [1:0]   occupancy, occupancy_nc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .CLEAR_DATA(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_reg #(.WIDTH(W), .CLEAR_DATA(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready_nc), .in_data(in_data),
        .out_valid(out_valid_nc), .out_ready(out_ready), .out_data(out_data_nc),
        .occupancy(occupancy_nc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the block in TWO holding a (head) then b, from EMPTY
    task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        tick();
        in_data = b;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    logic [W-1:0] q[$];
    logic         m_in_ready, m_out_valid;

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0; in_data = 16'hDEAD;

        // reset
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_data", out_data, 0);
            check_eq("rst_occ", occupancy, 0);
            check_eq("rst_nc_data", out_data_nc, 0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rel_in_ready", in_ready, 1);

        // streaming, one transfer per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = W'(i);
            tick();
            check_eq("stream_data", out_data, i);
            check_eq("stream_valid", out_valid, 1);
            check_eq("stream_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        tick();
        check_eq("stream_drain", occupancy, 0);

        // backpressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        tick();
        in_data = 16'h000B;
        #1;
        check_eq("bp_ready_same_cycle", in_ready, 1);
        tick();
        check_eq("bp_occ", occupancy, 2);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_head", out_data, 16'h000A);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("bp_pop_valid", out_valid, 1);
        tick();
        check_eq("bp_second", out_data, 16'h000B);
        check_eq("bp_occ1", occupancy, 1);
        tick();
        check_eq("bp_empty", occupancy, 0);

        // freeze holds everything and hides handshakes
        fill_two(16'h000A, 16'h000B);
        freeze = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("frz_out_valid", out_valid, 0);
            check_eq("frz_in_ready", in_ready, 0);
            check_eq("frz_occ", occupancy, 2);
            tick();
        end
        freeze = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("frz_first", out_data, 16'h000A);
        check_eq("frz_first_valid", out_valid, 1);
        tick();
        check_eq("frz_second", out_data, 16'h000B);
        check_eq("frz_occ1", occupancy, 1);
        tick();
        check_eq("frz_empty", occupancy, 0);

        // flush overrides freeze and drops the concurrent push
        fill_two(16'h000A, 16'h000B);
        flush = 1'b1; freeze = 1'b1; in_valid = 1'b1; in_data = 16'h0005;
        tick();
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("fl_occ", occupancy, 0);
        check_eq("fl_out_valid", out_valid, 0);
        check_eq("fl_data_clear", out_data, 0);
        check_eq("fl_data_hold", out_data_nc, 16'h000A);
        check_eq("fl_nc_occ", occupancy_nc, 0);

        // reset while holding two entries
        fill_two(16'h0033, 16'h0044);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst2_occ", occupancy, 0);
        check_eq("rst2_nc_data", out_data_nc, 0);
        check_eq("rst2_in_ready", in_ready, 1);

        // random soak against a queue model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            freeze    = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = W'($urandom_range(0, 255));
            #1;
            m_in_ready  = (q.size() < 2) && !freeze;
            m_out_valid = (q.size() > 0) && !freeze;
            check_eq("soak_in_ready", in_ready, m_in_ready);
            check_eq("soak_out_valid", out_valid, m_out_valid);
            check_eq("soak_nc_in_ready", in_ready_nc, m_in_ready);
            check_eq("soak_nc_out_valid", out_valid_nc, m_out_valid);
            if (m_out_valid && out_ready) check_eq("soak_data", out_data, q[0]);
            if (flush) begin
                q.delete();
            end else if (!freeze) begin
                if (m_out_valid && out_ready) void'(q.pop_front());
                if (m_in_ready && in_valid) q.push_back(in_data);
            end
            tick();
            check_eq("soak_occ", occupancy, q.size());
            check_eq("soak_occ_max", occupancy <= 2'd2, 1);
            check_eq("soak_nc_occ", occupancy_nc, q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
